// File: rtl/blockmem_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module   : blockmem_rd_stream
//  Purpose  : Read-side streaming engine for a blockmem_2p read port. On a
//             start command it walks a contiguous (wrapping) address range,
//             issuing one read per cycle on enb/addrb, captures doutb one
//             cycle later into a 4-entry skid FIFO, and presents the words as
//             a valid/ready stream with tlast on the final beat.
//  Ports    : clk, rstn              - clock, asynchronous active-low reset
//             start/start_addr/start_len - transfer command (IDLE only)
//             busy, done             - transfer status / completion pulse
//             enb, addrb, doutb      - memory read port (1-cycle latency)
//             m_tvalid/m_tready/m_tdata/m_tlast - output stream
//             abort                  - only with BLOCKMEM_RD_STREAM_ABORT_EN
//  Options  : BLOCKMEM_RD_STREAM_ABORT_EN adds the abort input, which flushes
//             the FIFO, drops in-flight reads and returns to IDLE silently.
//  Revision : 1.0 - initial release
// ============================================================================
module blockmem_rd_stream #(
    parameter int G_DATAWIDTH = 32,
    parameter int G_MEMDEPTH  = 1024,
    parameter int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
    parameter int G_LENWIDTH  = G_ADDRWIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
`ifdef BLOCKMEM_RD_STREAM_ABORT_EN
    input  logic                   abort,
`endif
    input  logic [G_ADDRWIDTH-1:0] start_addr,
    input  logic [G_LENWIDTH-1:0]  start_len,
    output logic                   busy,
    output logic                   done,
    output logic                   enb,
    output logic [G_ADDRWIDTH-1:0] addrb,
    input  logic [G_DATAWIDTH-1:0] doutb,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [G_DATAWIDTH-1:0] m_tdata,
    output logic                   m_tlast
);

    localparam logic [G_ADDRWIDTH-1:0] c_LAST_ADDR  = G_ADDRWIDTH'(G_MEMDEPTH - 1);
    localparam int                     c_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic                     r_enb;
    logic [G_ADDRWIDTH-1:0]   r_addrb;
    logic [G_LENWIDTH-1:0]    r_len;
    logic [G_LENWIDTH-1:0]    r_issued;
    logic [G_LENWIDTH-1:0]    r_accepted;
    logic                     r_rd_vld;     // a read was on the port last cycle
    logic                     r_done;

    logic [G_DATAWIDTH-1:0]   r_fifo_mem [0:c_FIFO_DEPTH-1];
    logic [1:0]               r_wr_ptr;
    logic [1:0]               r_rd_ptr;
    logic [2:0]               r_count;

    logic                     w_abort;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_issue;
    logic                     w_start_ok;
    logic                     w_start_zero;
    logic                     w_xfer_end;
    logic [2:0]               w_inflight;
    logic [G_ADDRWIDTH-1:0]   w_next_addr;

`ifdef BLOCKMEM_RD_STREAM_ABORT_EN
    assign w_abort = abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // Reads already committed but not yet in the FIFO: the one on the port
    // now (r_enb) and the one whose data is on doutb now (r_rd_vld). The
    // decision made this cycle becomes next cycle's r_enb, so keeping this
    // sum at 3 or less guarantees a free FIFO slot for every issued read.
    assign w_inflight  = r_count + {2'b00, r_enb} + {2'b00, r_rd_vld};
    assign w_next_addr = (r_addrb == c_LAST_ADDR) ? '0 : r_addrb + 1'b1;

    assign w_pop  = m_tvalid && m_tready;
    assign w_push = r_rd_vld && !w_abort;

    // ------------------------------------------------------------------
    // Next-state / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_start_ok   = 1'b0;
        w_start_zero = 1'b0;
        w_xfer_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (start_len != '0) begin
                        w_start_ok  = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_start_zero = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (r_issued == r_len) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_inflight <= 3'd3) begin
                    w_issue = 1'b1;
                end
            end
            S_DRAIN: begin
                // The tlast handshake empties the FIFO by definition.
                if (w_pop && m_tlast) begin
                    w_xfer_end  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_issue     = 1'b0;
            w_xfer_end  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM, read issue and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_enb      <= 1'b0;
            r_addrb    <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_accepted <= '0;
            r_rd_vld   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_done   <= w_start_zero | w_xfer_end;
            // A read on the port during an abort is dropped, not captured.
            r_rd_vld <= r_enb && !w_abort;

            if (w_abort) begin
                r_enb    <= 1'b0;
                r_issued <= '0;
            end else if (w_start_ok) begin
                // First read goes out straight from IDLE to hit N+1 latency.
                r_enb    <= 1'b1;
                r_addrb  <= start_addr;
                r_len    <= start_len;
                r_issued <= G_LENWIDTH'(1);
            end else if (w_issue) begin
                r_enb    <= 1'b1;
                r_addrb  <= w_next_addr;
                r_issued <= r_issued + 1'b1;
            end else begin
                r_enb    <= 1'b0;
            end

            if (w_abort || w_start_ok) begin
                r_accepted <= '0;
            end else if (w_pop) begin
                r_accepted <= r_accepted + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // 4-entry skid FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < c_FIFO_DEPTH; i++) begin
                r_fifo_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= doutb;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign enb      = r_enb;
    assign addrb    = r_addrb;
    assign m_tvalid = (r_count != 3'd0);
    assign m_tdata  = r_fifo_mem[r_rd_ptr];
    // Head of FIFO is beat number r_accepted (0-based).
    assign m_tlast  = m_tvalid && (r_accepted == (r_len - 1'b1));

endmodule
`default_nettype wire

// File: tb/tb_blockmem_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blockmem_rd_stream
//  Purpose  : Self-checking bench for blockmem_rd_stream. A behavioural
//             memory answers the read port; expected beats are computed as
//             mem[(start_addr + i) mod depth] for i in 0..len-1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_blockmem_rd_stream;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [9:0]  start_addr;
    logic [10:0] start_len;
    logic        busy;
    logic        done;
    logic        enb;
    logic [9:0]  addrb;
    logic [31:0] doutb;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;
`ifdef BLOCKMEM_RD_STREAM_ABORT_EN
    logic        abort;
`endif

    logic [31:0] mem [0:DEPTH-1];

    int n_tests;
    int n_fail;

    // capture results of do_xfer
    logic [31:0] cap_data[$];
    bit          cap_last[$];
    int          cap_hs_cyc[$];
    int          cap_addr[$];
    int          cap_enb_cyc[$];
    int          cap_first_valid;
    int          cap_done_cyc;
    int          cap_stall_err;
    int          cap_max_out;
    int          cap_busy_err;
    bit          cap_busy_at_done;
    bit          cap_timeout;
    bit          cap_done_after;
    bit          cap_busy_after;

    blockmem_rd_stream dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
`ifdef BLOCKMEM_RD_STREAM_ABORT_EN
        .abort      (abort),
`endif
        .start_addr (start_addr),
        .start_len  (start_len),
        .busy       (busy),
        .done       (done),
        .enb        (enb),
        .addrb      (addrb),
        .doutb      (doutb),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural memory read port, 1-cycle latency
    always @(posedge clk) begin
        if (enb) doutb <= mem[addrb];
    end

    // Runs one transfer and records what the stream/port did. Cycle k is
    // the k-th cycle after the one in which start was high.
    // rmode: 0 always ready, 1 pattern 1,0,0,1,0,1, 2 random (75% ready)
    task automatic do_xfer(input int a, input int l, input int rmode,
                           input int inj_cyc, input int budget);
        int k, issued, accepted;
        bit pv, pl, rdy;
        logic [31:0] pd;
        cap_data.delete(); cap_last.delete(); cap_hs_cyc.delete();
        cap_addr.delete(); cap_enb_cyc.delete();
        cap_first_valid = -1; cap_done_cyc = -1; cap_stall_err = 0;
        cap_max_out = 0; cap_busy_err = 0; cap_busy_at_done = 1'b0;
        @(negedge clk);
        start = 1'b1; start_addr = 10'(a); start_len = 11'(l); m_tready = 1'b0;
        k = 0; issued = 0; accepted = 0; pv = 1'b0; pl = 1'b0; pd = '0;
        while (cap_done_cyc < 0 && k < budget) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (k == inj_cyc) begin
                start = 1'b1; start_addr = 10'h300; start_len = 11'd5;
            end
            if (pv && (!m_tvalid || m_tdata !== pd || m_tlast !== pl)) cap_stall_err++;
            if (enb) begin
                issued++;
                cap_addr.push_back(int'(addrb));
                cap_enb_cyc.push_back(k);
            end
            if (issued - accepted > cap_max_out) cap_max_out = issued - accepted;
            if (m_tvalid && cap_first_valid < 0) cap_first_valid = k;
            if (done) begin
                cap_done_cyc = k;
                cap_busy_at_done = busy;
            end else if (!busy) begin
                cap_busy_err++;
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 6 == 0) || (k % 6 == 3) || (k % 6 == 5);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            m_tready = rdy;
            if (m_tvalid && rdy) begin
                cap_data.push_back(m_tdata);
                cap_last.push_back(m_tlast);
                cap_hs_cyc.push_back(k);
                accepted++;
                pv = 1'b0;
            end else begin
                pv = m_tvalid; pd = m_tdata; pl = m_tlast;
            end
        end
        cap_timeout = (cap_done_cyc < 0);
        @(negedge clk);
        start = 1'b0;
        cap_done_after = done;
        cap_busy_after = busy;
        m_tready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; start_addr = '0; start_len = '0; m_tready = 1'b0;
`ifdef BLOCKMEM_RD_STREAM_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, done, enb, addrb, m_tvalid, m_tdata, m_tlast} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b enb=%b addrb=%h valid=%b data=%h last=%b, want all 0",
                     busy, done, enb, addrb, m_tvalid, m_tdata, m_tlast);
        end
        rstn = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: busy=%b valid=%b want 0 0", busy, m_tvalid);
        end
    endtask

    task automatic test_basic();
        do_xfer(16, 8, 0, -1, 100);
        n_tests++;
        if (cap_timeout) begin n_fail++; $display("FAIL basic_timeout: no done within budget"); end
        n_tests++;
        if (cap_enb_cyc.size() == 0 || cap_enb_cyc[0] != 1) begin
            n_fail++; $display("FAIL basic_enb_latency: first enb cycle %0d want 1",
                               cap_enb_cyc.size() ? cap_enb_cyc[0] : -1);
        end
        n_tests++;
        if (cap_addr.size() != 8) begin n_fail++; $display("FAIL basic_nreads: got %0d want 8", cap_addr.size()); end
        for (int i = 0; i < cap_addr.size() && i < 8; i++) begin
            n_tests++;
            if (cap_addr[i] != 16 + i) begin n_fail++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, cap_addr[i], 16 + i); end
        end
        n_tests++;
        if (cap_first_valid != 3) begin n_fail++; $display("FAIL basic_valid_latency: got %0d want 3", cap_first_valid); end
        n_tests++;
        if (cap_data.size() != 8) begin n_fail++; $display("FAIL basic_nbeats: got %0d want 8", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 8; i++) begin
            n_tests++;
            if (cap_data[i] !== mem[16 + i] || cap_last[i] !== (i == 7) || cap_hs_cyc[i] != 3 + i) begin
                n_fail++;
                $display("FAIL basic_beat[%0d]: got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d",
                         i, cap_data[i], cap_last[i], cap_hs_cyc[i], mem[16 + i], (i == 7), 3 + i);
            end
        end
        n_tests++;
        if (cap_done_cyc != 11 || cap_busy_at_done !== 1'b0 || cap_busy_err != 0 || cap_done_after !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: done_cyc=%0d busy_at_done=%b busy_gaps=%0d done_next=%b want 11 0 0 0",
                     cap_done_cyc, cap_busy_at_done, cap_busy_err, cap_done_after);
        end
    endtask

    task automatic test_wrap();
        int a, l;
        do_xfer(1022, 4, 0, -1, 100);
        n_tests++;
        if (cap_addr.size() != 4) begin n_fail++; $display("FAIL wrap_nreads: got %0d want 4", cap_addr.size()); end
        for (int i = 0; i < cap_addr.size() && i < 4; i++) begin
            n_tests++;
            if (cap_addr[i] != (1022 + i) % DEPTH) begin
                n_fail++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, cap_addr[i], (1022 + i) % DEPTH);
            end
        end
        n_tests++;
        if (cap_data.size() != 4) begin n_fail++; $display("FAIL wrap_nbeats: got %0d want 4", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 4; i++) begin
            n_tests++;
            if (cap_data[i] !== mem[(1022 + i) % DEPTH] || cap_last[i] !== (i == 3)) begin
                n_fail++; $display("FAIL wrap_beat[%0d]: got %h/%b want %h/%b", i, cap_data[i], cap_last[i],
                                   mem[(1022 + i) % DEPTH], (i == 3));
            end
        end
        // length above the depth wraps more than once
        a = 1000; l = 1100;
        do_xfer(a, l, 0, -1, 1300);
        n_tests++;
        if (cap_timeout || cap_data.size() != l) begin
            n_fail++; $display("FAIL long_nbeats: got %0d timeout=%b want %0d", cap_data.size(), cap_timeout, l);
        end
        begin
            int errs;
            errs = 0;
            for (int i = 0; i < cap_data.size() && i < l; i++) begin
                if (cap_data[i] !== mem[(a + i) % DEPTH] || cap_last[i] !== (i == l - 1) || cap_hs_cyc[i] != 3 + i) errs++;
            end
            n_tests++;
            if (errs != 0) begin n_fail++; $display("FAIL long_beats: %0d bad beats want 0", errs); end
        end
    endtask

    task automatic test_backpressure();
        do_xfer(0, 6, 1, -1, 200);
        n_tests++;
        if (cap_timeout || cap_data.size() != 6) begin
            n_fail++; $display("FAIL bp_nbeats: got %0d timeout=%b want 6", cap_data.size(), cap_timeout);
        end
        for (int i = 0; i < cap_data.size() && i < 6; i++) begin
            n_tests++;
            if (cap_data[i] !== mem[i] || cap_last[i] !== (i == 5)) begin
                n_fail++; $display("FAIL bp_beat[%0d]: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], mem[i], (i == 5));
            end
        end
        n_tests++;
        if (cap_stall_err != 0) begin n_fail++; $display("FAIL bp_stall_stable: %0d unstable cycles want 0", cap_stall_err); end
        n_tests++;
        if (cap_max_out > 4) begin n_fail++; $display("FAIL bp_inflight: max %0d want <=4", cap_max_out); end
        n_tests++;
        if (cap_hs_cyc.size() != 0 && cap_done_cyc != cap_hs_cyc[cap_hs_cyc.size() - 1] + 1) begin
            n_fail++; $display("FAIL bp_done_cyc: got %0d want %0d", cap_done_cyc, cap_hs_cyc[cap_hs_cyc.size() - 1] + 1);
        end
    endtask

    task automatic test_zero_len();
        do_xfer(5, 0, 0, -1, 20);
        n_tests++;
        if (cap_done_cyc != 1) begin n_fail++; $display("FAIL zero_done_cyc: got %0d want 1", cap_done_cyc); end
        n_tests++;
        if (cap_enb_cyc.size() != 0 || cap_first_valid != -1) begin
            n_fail++; $display("FAIL zero_activity: reads=%0d first_valid=%0d want 0 -1", cap_enb_cyc.size(), cap_first_valid);
        end
        n_tests++;
        if (cap_busy_at_done !== 1'b0 || cap_busy_after !== 1'b0 || cap_done_after !== 1'b0) begin
            n_fail++; $display("FAIL zero_busy: busy=%b/%b done_next=%b want 0/0 0", cap_busy_at_done, cap_busy_after, cap_done_after);
        end
    endtask

    task automatic test_start_while_busy();
        do_xfer(128, 8, 0, 5, 100);
        n_tests++;
        if (cap_timeout || cap_data.size() != 8 || cap_addr.size() != 8) begin
            n_fail++; $display("FAIL busy_start_counts: beats=%0d reads=%0d want 8 8", cap_data.size(), cap_addr.size());
        end
        for (int i = 0; i < cap_data.size() && i < 8; i++) begin
            n_tests++;
            if (cap_data[i] !== mem[128 + i] || cap_last[i] !== (i == 7)) begin
                n_fail++; $display("FAIL busy_start_beat[%0d]: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], mem[128 + i], (i == 7));
            end
        end
        n_tests++;
        if (cap_busy_after !== 1'b0 || enb !== 1'b0) begin
            n_fail++; $display("FAIL busy_start_idle: busy=%b enb=%b want 0 0", cap_busy_after, enb);
        end
    endtask

    task automatic test_reset_mid();
        int k, hs;
        bit hit;
        @(negedge clk);
        start = 1'b1; start_addr = 10'h040; start_len = 11'd8; m_tready = 1'b1;
        k = 0; hs = 0; hit = 1'b0;
        while (!hit && k < 50) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (m_tvalid && hs == 2) begin
                rstn = 1'b0;
                hit = 1'b1;
            end else if (m_tvalid) begin
                hs++;
            end
        end
        #1;
        n_tests++;
        if (!hit || {busy, done, enb, addrb, m_tvalid, m_tdata, m_tlast} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: hit=%b busy=%b done=%b enb=%b addrb=%h valid=%b data=%h last=%b want all 0",
                     hit, busy, done, enb, addrb, m_tvalid, m_tdata, m_tlast);
        end
        @(negedge clk);
        rstn = 1'b1;
        m_tready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL reset_mid_quiet: done=%b busy=%b want 0 0", done, busy);
            end
        end
        do_xfer(1023, 2, 0, -1, 50);
        n_tests++;
        if (cap_timeout || cap_data.size() != 2) begin
            n_fail++; $display("FAIL reset_mid_after_n: got %0d want 2", cap_data.size());
        end
        for (int i = 0; i < cap_data.size() && i < 2; i++) begin
            n_tests++;
            if (cap_data[i] !== mem[(1023 + i) % DEPTH] || cap_last[i] !== (i == 1)) begin
                n_fail++; $display("FAIL reset_mid_after[%0d]: got %h/%b want %h/%b", i, cap_data[i], cap_last[i],
                                   mem[(1023 + i) % DEPTH], (i == 1));
            end
        end
    endtask

`ifdef BLOCKMEM_RD_STREAM_ABORT_EN
    task automatic test_abort();
        int k, hs;
        bit hit;
        @(negedge clk);
        start = 1'b1; start_addr = 10'h100; start_len = 11'd10; m_tready = 1'b0;
        k = 0; hs = 0; hit = 1'b0;
        while (!hit && k < 50) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            m_tready = (hs == 0);
            if (hs == 1 && m_tvalid) begin
                abort = 1'b1;
                hit = 1'b1;
            end else if (m_tvalid && m_tready) begin
                hs++;
            end
        end
        @(negedge clk);
        abort = 1'b0;
        n_tests++;
        if (!hit || m_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || enb !== 1'b0) begin
            n_fail++; $display("FAIL abort_state: hit=%b valid=%b busy=%b done=%b enb=%b want 1 0 0 0 0",
                               hit, m_tvalid, busy, done, enb);
        end
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0 || m_tvalid !== 1'b0) begin
                n_fail++; $display("FAIL abort_quiet: done=%b valid=%b want 0 0", done, m_tvalid);
            end
        end
        do_xfer(512, 5, 0, -1, 50);
        n_tests++;
        if (cap_timeout || cap_data.size() != 5) begin
            n_fail++; $display("FAIL abort_after_n: got %0d want 5", cap_data.size());
        end
        for (int i = 0; i < cap_data.size() && i < 5; i++) begin
            n_tests++;
            if (cap_data[i] !== mem[512 + i] || cap_last[i] !== (i == 4)) begin
                n_fail++; $display("FAIL abort_after[%0d]: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], mem[512 + i], (i == 4));
            end
        end
    endtask
`endif

    task automatic test_random();
        int a, l, errs;
        for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
        for (int it = 0; it < 8; it++) begin
            a = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, 40);
            do_xfer(a, l, 2, -1, l * 8 + 50);
            errs = 0;
            for (int i = 0; i < cap_data.size() && i < l; i++) begin
                if (cap_data[i] !== mem[(a + i) % DEPTH] || cap_last[i] !== (i == l - 1)) errs++;
            end
            n_tests++;
            if (cap_timeout || cap_data.size() != l || errs != 0 || cap_stall_err != 0 || cap_max_out > 4) begin
                n_fail++;
                $display("FAIL random[%0d] a=%0d l=%0d: beats=%0d bad=%0d stall=%0d maxout=%0d timeout=%b want %0d 0 0 <=4 0",
                         it, a, l, cap_data.size(), errs, cap_stall_err, cap_max_out, cap_timeout, l);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int k = 0; k < DEPTH; k++) mem[k] = k;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_start_while_busy();
        test_reset_mid();
`ifdef BLOCKMEM_RD_STREAM_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/blockmem_rd_stream.md
Name: blockmem_rd_stream

Overview:
- Read-side streaming engine for a blockmem_2p instance: on a start command, walks a contiguous address range on the memory's read port (enb/addrb/doutb, 1-cycle read latency) and presents the words as a valid/ready stream with tlast.
- Absorbs read latency and downstream backpressure with a 4-entry internal skid FIFO.
- Sustains 1 beat/cycle when m_tready is held high.

Parameters:
- G_DATAWIDTH, 32, word width; must equal the memory's G_DATAWIDTH.
- G_MEMDEPTH, 1024, memory depth in words; address wrap point.
- G_ADDRWIDTH, $clog2(G_MEMDEPTH), read address width.
- G_LENWIDTH, G_ADDRWIDTH+1, width of the transfer length field.

Ports:
- clk  in  1  single clock; the memory's clkb is tied to this clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  command pulse; sampled only in IDLE.
- start_addr  in  G_ADDRWIDTH  first word address.
- start_len  in  G_LENWIDTH  number of words to stream.
- busy  out  1  transfer in progress.
- done  out  1  1-cycle pulse when the transfer completes.
- enb  out  1  memory read enable.
- addrb  out  G_ADDRWIDTH  memory read address.
- doutb  in  G_DATAWIDTH  memory read data; valid the cycle after enb.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tdata  out  G_DATAWIDTH  stream data.
- m_tlast  out  1  marks the final beat.

Behaviour:
- Reset (async, rstn=0):
  - All outputs are 0: busy, done, enb, addrb, m_tvalid, m_tdata, m_tlast.
  - FIFO is emptied, counters are cleared, FSM goes to IDLE.
  - A reset mid-transfer discards all state; no done pulse is produced.
- FSM states:
  - IDLE: start=1 with start_len≠0 latches addr and len → RUN, busy=1 from the next cycle. start=1 with start_len=0 → done pulses the next cycle; busy stays 0; no reads are issued.
  - RUN: issues reads; → DRAIN once the issue counter reaches start_len.
  - DRAIN: waits for the FIFO to empty and the last beat to be accepted → IDLE. done=1 and busy=0 in the cycle after the tlast handshake.
  - start is ignored while busy.
- Read issue:
  - enb=1 in RUN when issued<len AND (fifo_count + pending) ≤ 3.
  - pending = reads issued but not yet written into the FIFO, range 0..2. Data is captured from doutb at the end of the cycle after enb.
  - addrb increments by 1 per issued read and wraps from G_MEMDEPTH-1 to 0.
  - Lengths above G_MEMDEPTH wrap repeatedly.
- Latency: start high in cycle N → enb high in N+1 with addrb=start_addr → doutb valid in N+2 → m_tvalid high in N+3.
- Stream rules:
  - m_tdata and m_tvalid are driven from registers (FIFO head).
  - Once m_tvalid=1, m_tdata and m_tlast hold stable until m_tready=1.
  - m_tvalid never deasserts without a handshake, except on reset or abort.
  - m_tlast=1 only on beat number start_len.
- Counters: issued and accepted counters are G_LENWIDTH wide; the FIFO has 4 entries with a 3-bit count.
- Simultaneous push and pop on the FIFO leaves the count unchanged; a push never occurs when full, by construction of the issue rule.
- Throughput: with m_tready=1 continuously, steady state is fifo_count=1, pending=2, giving one beat per cycle and no bubbles after the first word.

Optional Feature:
- Macro: BLOCKMEM_RD_STREAM_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in RUN or DRAIN:
    - FIFO is flushed and pending reads are discarded; their doutb is not captured.
    - m_tvalid=0 and enb=0 from the next cycle.
    - FSM → IDLE with busy=0; done is not pulsed.
  - abort in IDLE has no effect.
  - If abort and start are both high in IDLE, start wins.
- Undefined: no abort port; a transfer always runs to completion or reset.

Test Plan:
- Memory preloaded with mem[k]=k; start_addr=0x010, start_len=8, m_tready=1 → enb high in N+1 with addrb 0x010..0x017. m_tvalid high in N+3, then data 0x10..0x17 on consecutive cycles. m_tlast on 0x17; done pulse one cycle later.
- start_addr=1022, start_len=4, G_MEMDEPTH=1024 → addrb sequence 1022, 1023, 0, 1. Data 1022, 1023, 0, 1 in order.
- start_len=6; m_tready toggles 1,0,0,1,0,1,…:
  - Every beat is 0..5 in order with no duplicates or loss.
  - m_tdata is stable while stalled; (fifo_count + pending) never exceeds 4.
- start_len=0 → no enb, no m_tvalid, busy stays 0, done pulses in N+1. A second start issued while busy mid-transfer → ignored; the first transfer completes unaffected.
- rstn asserted during beat 3 of 8 → all outputs 0 immediately. After release, a new start with start_len=2 streams correctly.
- With BLOCKMEM_RD_STREAM_ABORT_EN: abort during beat 2 of 10 with m_tready=0 → m_tvalid=0 next cycle, busy=0, no done. A following transfer returns the correct data.
